// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared widths, FSM state and owner encodings for mem_port_arbiter
package mem_port_arbiter_pkg;

   localparam int ARB_XLEN       = 64;
   localparam int ARB_MASK_W     = ARB_XLEN / 8;
   localparam int ARB_STARVE_MAX = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_port_arbiter_grant.sv
// rtl/mem_port_arbiter_grant.sv - LS-over-IF priority decision (module arb_grant)
// optional IF starvation guard under ARB_STARVE_GUARD_EN
module arb_grant
   import mem_port_arbiter_pkg::*;
`ifdef ARB_STARVE_GUARD_EN
#(
   parameter int STARVE_MAX = ARB_STARVE_MAX
)
`endif
(
`ifdef ARB_STARVE_GUARD_EN
   input  logic clk,
   input  logic rst,
   input  logic take,
`endif
   input  logic ls_valid,
   input  logic if_valid,
   output logic grant_ls,
   output logic grant_if
);

`ifdef ARB_STARVE_GUARD_EN
   logic [2:0] starve_cnt;
   logic       starve_hit;

   assign starve_hit = (starve_cnt == 3'(STARVE_MAX));

   always_comb begin
      grant_ls = 1'b0;
      grant_if = 1'b0;
      if (ls_valid && !(if_valid && starve_hit))
         grant_ls = 1'b1;
      else if (if_valid)
         grant_if = 1'b1;
   end

   // Only counts grants actually taken by the FSM; holds at 7 rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         starve_cnt <= '0;
      else if (take) begin
         if (grant_if)
            starve_cnt <= '0;
         else if (grant_ls && if_valid && (starve_cnt != 3'd7))
            starve_cnt <= starve_cnt + 3'd1;
      end
   end
`else
   always_comb begin
      grant_ls = ls_valid;
      grant_if = if_valid && !ls_valid;
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - one-outstanding-transaction arbiter sharing a memory port between IF and LS
// optional starvation guard: ARB_STARVE_GUARD_EN
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int XLEN   = ARB_XLEN,
   parameter int MASK_W = ARB_MASK_W
`ifdef ARB_STARVE_GUARD_EN
   ,
   parameter int STARVE_MAX = ARB_STARVE_MAX
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [XLEN-1:0]   if_addr,
   output logic              if_resp_valid,
   output logic [XLEN-1:0]   if_resp_data,
   input  logic              ls_req_valid,
   output logic              ls_req_ready,
   input  logic              ls_wren,
   input  logic [XLEN-1:0]   ls_addr,
   input  logic [XLEN-1:0]   ls_wdata,
   input  logic [MASK_W-1:0] ls_wmask,
   output logic              ls_resp_valid,
   output logic [XLEN-1:0]   ls_resp_data,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_wren,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [MASK_W-1:0] mem_wmask,
   input  logic              mem_resp_valid,
   input  logic [XLEN-1:0]   mem_resp_data
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(7);

   state_t              state, state_nxt;
   owner_t              owner;
   logic                lat_wren;
   logic [XLEN-1:0]     lat_addr;
   logic [XLEN-1:0]     lat_wdata;
   logic [MASK_W-1:0]   lat_wmask;
   logic                grant_ls, grant_if;
   logic                idle;

   assign idle = (state == IDLE);

   arb_grant
`ifdef ARB_STARVE_GUARD_EN
   #(.STARVE_MAX(STARVE_MAX))
`endif
   u_grant (
`ifdef ARB_STARVE_GUARD_EN
      .clk      (clk),
      .rst      (rst),
      .take     (idle),
`endif
      .ls_valid (ls_req_valid),
      .if_valid (if_req_valid),
      .grant_ls (grant_ls),
      .grant_if (grant_if)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_ls || grant_if) state_nxt = ISSUE;
         ISSUE:   if (mem_req_ready)        state_nxt = WAIT;
         WAIT:    if (mem_resp_valid)       state_nxt = IDLE;
         default:                           state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ls_req_ready  = idle && grant_ls;
      if_req_ready  = idle && grant_if;
      mem_req_valid = (state == ISSUE);
   end

   assign mem_wren  = lat_wren;
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;
   assign mem_wmask = lat_wmask;

   // Requester inputs are captured at acceptance so they may change freely afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner     <= OWN_IF;
         lat_wren  <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wmask <= '0;
      end else if (ls_req_ready) begin
         owner     <= OWN_LS;
         lat_wren  <= ls_wren;
         lat_addr  <= ls_addr & ALIGN_MASK;
         lat_wdata <= ls_wdata;
         lat_wmask <= ls_wmask;
      end else if (if_req_ready) begin
         owner     <= OWN_IF;
         lat_wren  <= 1'b0;
         lat_addr  <= if_addr & ALIGN_MASK;
         lat_wdata <= '0;
         lat_wmask <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_resp_valid <= 1'b0;
         if_resp_data  <= '0;
         ls_resp_valid <= 1'b0;
         ls_resp_data  <= '0;
      end else begin
         if_resp_valid <= 1'b0;
         ls_resp_valid <= 1'b0;
         if ((state == WAIT) && mem_resp_valid) begin
            if (owner == OWN_LS) begin
               ls_resp_valid <= 1'b1;
               ls_resp_data  <= lat_wren ? '0 : mem_resp_data;
            end else begin
               if_resp_valid <= 1'b1;
               if_resp_data  <= mem_resp_data;
            end
         end
      end
   end

   resp_in_issue: assert property (@(posedge clk) disable iff (rst)
      !((state == ISSUE) && mem_resp_valid));

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one 64-bit data-memory port between instruction fetch (IF) and load/store (LS) requesters in the pipelined core.
- Sits between the fetch stage / L_S stage and the memory model/bus.
- Sequences one outstanding transaction at a time: arbitrate, issue, wait for response, route the response.
- LS has fixed priority over IF.

Parameters:
- XLEN, 64, address/data width.
- MASK_W, 8, byte write-mask width (XLEN/8).
- STARVE_MAX, 4, maximum consecutive LS grants while IF waits (used only with the optional feature).

Ports:
- clk  input  1  core clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- if_req_valid  input  1  fetch request pending.
- if_req_ready  output  1  fetch request accepted this cycle.
- if_addr  input  XLEN  fetch address.
- if_resp_valid  output  1  fetch data valid, one-cycle pulse.
- if_resp_data  output  XLEN  fetch data (aligned doubleword).
- ls_req_valid  input  1  LS request pending.
- ls_req_ready  output  1  LS request accepted this cycle.
- ls_wren  input  1  1 = store, 0 = load.
- ls_addr  input  XLEN  LS address.
- ls_wdata  input  XLEN  store data, already merged/positioned.
- ls_wmask  input  MASK_W  store byte enables.
- ls_resp_valid  output  1  LS load data or store ack, one-cycle pulse.
- ls_resp_data  output  XLEN  load data (aligned doubleword); 0 for stores.
- mem_req_valid  output  1  request to memory.
- mem_req_ready  input  1  memory accepts request.
- mem_wren  output  1  write enable.
- mem_addr  output  XLEN  address, low 3 bits forced to 0.
- mem_wdata  output  XLEN  write data.
- mem_wmask  output  MASK_W  byte enables; 0 for reads.
- mem_resp_valid  input  1  memory response (reads and write acks).
- mem_resp_data  input  XLEN  read data.

Behaviour:
- Reset values: all outputs 0; state = IDLE; owner = IF; starve counter = 0. Reset asserted mid-transaction aborts it; no response pulse is emitted for the aborted transaction.

State IDLE:
- If ls_req_valid: assert ls_req_ready and latch {wren, addr & ~7, wdata, wmask, owner=LS}, then go to ISSUE.
- Else if if_req_valid: assert if_req_ready, latch {wren=0, addr & ~7, wmask=0, owner=IF}, then go to ISSUE.
- When both are valid in the same cycle, LS wins.
- The ready outputs are combinational and are only high in IDLE.

State ISSUE:
- mem_req_valid = 1, driven from latched registers, stable until mem_req_ready is seen.
- On mem_req_valid && mem_req_ready, go to WAIT.

State WAIT:
- mem_req_valid = 0.
- On mem_resp_valid:
  - Pulse the owner's resp_valid for exactly one cycle on the next edge (registered).
  - Data is registered from mem_resp_data; stores return 0.
  - Go to IDLE.

General rules:
- Minimum latency from request acceptance to resp_valid: 3 cycles (accept, issue with ready=1, response in the same cycle as WAIT, then registered pulse).
- Back-to-back throughput: one transaction per 3 cycles minimum.
- A response arriving in ISSUE is a protocol error; it is ignored. A simulation-only assertion flags it.
- mem_resp_valid in IDLE is ignored.
- The non-owner's resp_valid is never asserted.
- Requester inputs may change freely after acceptance because they are latched.
- Requests with misaligned addresses are aligned and not flagged. Byte selection is the requester's job.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- When defined:
  - A 3-bit counter increments on each LS grant made while if_req_valid is high, and clears on any IF grant.
  - When the counter equals STARVE_MAX and both are valid, IF wins and the counter clears.
  - The counter saturates and does not wrap.
- When undefined: pure fixed LS priority; the counter is not instantiated.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2), owner encoding (OWN_IF=1'b0, OWN_LS=1'b1), and the XLEN/MASK_W constants in the common defines.
- One sub-module, arb_grant: combinational priority decision plus the starve counter, outputs grant_ls/grant_if.
- FSM and latches stay in the top module.

Test Plan:
- Reset mid-WAIT with LS owning the transaction -> all outputs 0 next cycle; no ls_resp_valid; next if_req is accepted from IDLE.
- Lone IF read: if_addr=0x8000_0004, memory returns 0x1122334455667788 one cycle after ready -> mem_addr=0x8000_0000, mem_wmask=0; if_resp_valid pulses once with that data; ls_resp_valid stays 0.
- Simultaneous requests: IF read 0x8000_0000 and LS store addr 0x8000_0100, wdata 0xAB, wmask 0x01 -> LS issued first (mem_wren=1, mask 0x01); ls_resp_valid with data 0; then the IF read is accepted and completes.
- Memory backpressure: mem_req_ready low for 5 cycles -> mem_req_valid and mem_addr held constant; single transfer on the first ready cycle.
- Starve guard with ARB_STARVE_GUARD_EN and STARVE_MAX=4: LS and IF continuously valid -> grant order LS,LS,LS,LS,IF,LS...; without the macro, IF is never granted while LS is valid.
